// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-access stage: FSM states and the
// size/sign codes carried on ALU_Control.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables and replicated store lanes for a
// request, plus extraction and extension of the load value from a word.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [5:0]  code,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[31:24];
    half_sel  = rdata[31:16];
    be        = 4'b1111;
    wlanes    = wdata;
    rdata_ext = rdata;

    // Offset 0 is the most significant byte.
    case (addr_lo)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    case (code)
      LB, LBU, SB: begin
        be        = 4'b1000 >> addr_lo;
        wlanes    = {4{wdata[7:0]}};
        rdata_ext = (code == LB) ? {{24{byte_sel[7]}}, byte_sel}
                                 : {24'd0, byte_sel};
      end
      LH, LHU, SH: begin
        be        = addr_lo[1] ? 4'b0011 : 4'b1100;
        wlanes    = {2{wdata[15:0]}};
        rdata_ext = (code == LH) ? {{16{half_sel[15]}}, half_sel}
                                 : {16'd0, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack port,
// stalls upstream while outstanding, forwards results and registers WB.
module mem_stage
  import mem_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        MEM_miss,
  output logic [4:0]  BypassReg1_MEMEXE,
  output logic [31:0] BypassData1_MEMEXE,
  output logic        BypassValid1_MEMEXE,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output state_t      state_dbg
);

  state_t      state, state_nxt;
  logic        mem_op, start, in_access, busy, reg_write_eff;
  logic [31:0] req_addr, req_wdata, load_buf;
  logic [3:0]  req_be;
  logic        req_we;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_ext, wb_data;

  assign mem_op        = MemRead1_IN | MemWrite1_IN;
  assign start         = (state == IDLE) & mem_op;
  assign in_access     = (state == ACCESS);
  assign busy          = start | in_access;
  assign reg_write_eff = RegWrite1_IN & ~MemWrite1_IN;
  assign state_dbg     = state;

  mem_lane_align u_lane_align (
    .code      (ALU_Control1_IN),
    .addr_lo   (ALU_result1_IN[1:0]),
    .wdata     (MemWriteData1_IN),
    .rdata     (load_buf),
    .be        (lane_be),
    .wlanes    (lane_wdata),
    .rdata_ext (load_ext)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_op)  state_nxt = ACCESS;
      ACCESS:  if (mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gating with RESET keeps the request low the instant reset asserts.
  assign mem_req   = RESET & busy;
  assign MEM_miss  = RESET & busy;
  assign mem_we    = mem_req & (in_access ? req_we : MemWrite1_IN);
  assign mem_addr  = !mem_req ? 32'd0 :
                     in_access ? req_addr : {ALU_result1_IN[31:2], 2'b00};
  assign mem_be    = !mem_req ? 4'd0 : in_access ? req_be : lane_be;
  assign mem_wdata = !mem_req ? 32'd0 : in_access ? req_wdata : lane_wdata;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      req_we    <= 1'b0;
      load_buf  <= '0;
    end else begin
      if (start) begin
        req_addr  <= {ALU_result1_IN[31:2], 2'b00};
        req_wdata <= lane_wdata;
        req_be    <= lane_be;
        req_we    <= MemWrite1_IN;
      end
      if (in_access && mem_ack) load_buf <= mem_rdata;
    end
  end

  assign wb_data             = MemRead1_IN ? load_ext : ALU_result1_IN;
  assign BypassReg1_MEMEXE   = WriteRegister1_IN;
  assign BypassData1_MEMEXE  = wb_data;
  assign BypassValid1_MEMEXE = reg_write_eff & (~mem_op | (state == DONE));

  // A stalled op hands WB a bubble until its DONE cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Instr1_OUT         <= '0;
      Instr1_PC_OUT      <= '0;
      WriteData1_OUT     <= '0;
      WriteRegister1_OUT <= '0;
      RegWrite1_OUT      <= 1'b0;
    end else if (busy) begin
      Instr1_OUT         <= '0;
      Instr1_PC_OUT      <= '0;
      WriteData1_OUT     <= '0;
      WriteRegister1_OUT <= '0;
      RegWrite1_OUT      <= 1'b0;
    end else begin
      Instr1_OUT         <= Instr1_IN;
      Instr1_PC_OUT      <= Instr1_PC_IN;
      WriteData1_OUT     <= wb_data;
      WriteRegister1_OUT <= WriteRegister1_IN;
      RegWrite1_OUT      <= reg_write_eff;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scripted ops with expected WB records
// and memory requests queued at drive time and compared as the DUT responds.
module tb_mem_stage;
  import mem_ctrl_pkg::*;

  logic        CLK, RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        mem_req, mem_we, mem_ack, MEM_miss;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [4:0]  BypassReg1_MEMEXE;
  logic [31:0] BypassData1_MEMEXE;
  logic        BypassValid1_MEMEXE;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
  logic [4:0]  WriteRegister1_OUT;
  logic        RegWrite1_OUT;
  state_t      state_dbg;

  int compared   = 0;
  int mismatches = 0;
  int cyc        = 0;
  int ack_cnt    = 0;
  int start_cyc, done_cyc;

  // WB record: {RegWrite, WriteRegister, WriteData, Instr}
  logic [69:0] exp_q[$];
  // Request record: {we, addr, be, wdata}
  logic [68:0] req_q[$];

  mem_stage dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
    .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .MEM_miss(MEM_miss),
    .BypassReg1_MEMEXE(BypassReg1_MEMEXE), .BypassData1_MEMEXE(BypassData1_MEMEXE),
    .BypassValid1_MEMEXE(BypassValid1_MEMEXE),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET && mem_req && mem_ack) ack_cnt <= ack_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive_idle();
    Instr1_IN = '0; Instr1_PC_IN = '0; ALU_result1_IN = '0; MemWriteData1_IN = '0;
    WriteRegister1_IN = '0; RegWrite1_IN = 0; MemRead1_IN = 0; MemWrite1_IN = 0;
    ALU_Control1_IN = '0;
  endtask

  // Called just after a falling edge; returns just after a later falling edge.
  task automatic run_mem(input string name, input logic rd, input logic wr,
                         input logic rw, input logic [5:0] code, input logic [4:0] dst,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_cycle,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
    logic [68:0] rq;
    logic [69:0] wq;
    logic [31:0] pc;
    int miss_cnt;
    bit done;
    Instr1_IN = $urandom; pc = $urandom; Instr1_PC_IN = pc;
    ALU_result1_IN = addr; MemWriteData1_IN = sdata; WriteRegister1_IN = dst;
    RegWrite1_IN = rw; MemRead1_IN = rd; MemWrite1_IN = wr; ALU_Control1_IN = code;
    req_q.push_back({wr, exp_addr, exp_be, exp_wdata});
    exp_q.push_back({rw & ~wr, dst, exp_wb, Instr1_IN});
    miss_cnt = 0;
    done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (k == 0) begin
        start_cyc = cyc;
        compared++;
        if (state_dbg !== IDLE) begin
          mismatches++;
          $display("FAIL %s start_state: got %0d required %0d", name, state_dbg, IDLE);
        end
      end
      if (MEM_miss === 1'b1 || k == 0) begin
        if (MEM_miss === 1'b1) miss_cnt++;
        rq = req_q[0];
        compared++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, rq}) begin
          mismatches++;
          $display("FAIL %s request k=%0d: got req=%b we=%b addr=%h be=%b wdata=%h required req=1 we=%b addr=%h be=%b wdata=%h",
                   name, k, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   rq[68], rq[67:36], rq[35:32], rq[31:0]);
        end
        compared++;
        if (BypassValid1_MEMEXE !== 1'b0) begin
          mismatches++;
          $display("FAIL %s bypass_in_stall k=%0d: got %b required 0", name, k, BypassValid1_MEMEXE);
        end
        if (k > 0) begin
          compared++;
          if ({RegWrite1_OUT, WriteRegister1_OUT, WriteData1_OUT, Instr1_OUT, Instr1_PC_OUT} !== '0) begin
            mismatches++;
            $display("FAIL %s wb_bubble k=%0d: got rw=%b reg=%0d data=%h required all zero",
                     name, k, RegWrite1_OUT, WriteRegister1_OUT, WriteData1_OUT);
          end
        end
        if (k == ack_cycle) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
          void'(req_q.pop_front());
        end
      end else begin
        done = 1;
        done_cyc = cyc;
        compared++;
        if (state_dbg !== DONE || mem_req !== 1'b0) begin
          mismatches++;
          $display("FAIL %s done_state: got state=%0d req=%b required state=%0d req=0",
                   name, state_dbg, mem_req, DONE);
        end
        compared++;
        if (BypassValid1_MEMEXE !== (rw & ~wr) ||
            (rw & ~wr & (BypassData1_MEMEXE !== exp_wb || BypassReg1_MEMEXE !== dst))) begin
          mismatches++;
          $display("FAIL %s bypass_done: got v=%b reg=%0d data=%h required v=%b reg=%0d data=%h",
                   name, BypassValid1_MEMEXE, BypassReg1_MEMEXE, BypassData1_MEMEXE,
                   rw & ~wr, dst, exp_wb);
        end
      end
      if (!done) begin
        @(negedge CLK);
        mem_ack = 1'b0;
      end
    end
    compared++;
    if (!done) begin
      mismatches++;
      $display("FAIL %s timeout: got no DONE required DONE within 64 cycles", name);
    end
    compared++;
    if (miss_cnt != 1 + ack_cycle) begin
      mismatches++;
      $display("FAIL %s miss_cycles: got %0d required %0d", name, miss_cnt, 1 + ack_cycle);
    end
    @(negedge CLK);
    wq = exp_q.pop_front();
    compared++;
    if ({RegWrite1_OUT, WriteRegister1_OUT, WriteData1_OUT, Instr1_OUT} !== wq ||
        Instr1_PC_OUT !== pc) begin
      mismatches++;
      $display("FAIL %s wb: got rw=%b reg=%0d data=%h pc=%h required rw=%b reg=%0d data=%h pc=%h",
               name, RegWrite1_OUT, WriteRegister1_OUT, WriteData1_OUT, Instr1_PC_OUT,
               wq[69], wq[68:64], wq[63:32], pc);
    end
  endtask

  // Test scenarios
  task automatic test_reset();
    drive_idle();
    mem_ack = 0; mem_rdata = '0;
    RESET = 0;
    #2;
    MemRead1_IN = 1; ALU_Control1_IN = LW; ALU_result1_IN = 32'h100;
    #10;
    compared++;
    if (mem_req !== 0 || MEM_miss !== 0 || state_dbg !== IDLE) begin
      mismatches++;
      $display("FAIL reset_hold: got req=%b miss=%b state=%0d required 0 0 IDLE",
               mem_req, MEM_miss, state_dbg);
    end
    compared++;
    if ({RegWrite1_OUT, WriteRegister1_OUT, WriteData1_OUT, Instr1_OUT, Instr1_PC_OUT} !== '0) begin
      mismatches++;
      $display("FAIL reset_outputs: got data=%h instr=%h required 0", WriteData1_OUT, Instr1_OUT);
    end
    drive_idle();
    @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
  endtask

  task automatic test_alu_op();
    logic [69:0] wq;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] res;
      logic        rw;
      logic [4:0]  dst;
      res = (i == 0) ? 32'h1234 : $urandom;
      rw  = (i == 1) ? 1'b0 : 1'b1;
      dst = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
      Instr1_IN = $urandom; Instr1_PC_IN = $urandom; ALU_result1_IN = res;
      WriteRegister1_IN = dst; RegWrite1_IN = rw; MemRead1_IN = 0; MemWrite1_IN = 0;
      ALU_Control1_IN = 6'($urandom_range(0, 31)); MemWriteData1_IN = $urandom;
      exp_q.push_back({rw, dst, res, Instr1_IN});
      #1;
      compared++;
      if (BypassValid1_MEMEXE !== rw || (rw && (BypassData1_MEMEXE !== res || BypassReg1_MEMEXE !== dst))) begin
        mismatches++;
        $display("FAIL alu_bypass %0d: got v=%b reg=%0d data=%h required v=%b reg=%0d data=%h",
                 i, BypassValid1_MEMEXE, BypassReg1_MEMEXE, BypassData1_MEMEXE, rw, dst, res);
      end
      compared++;
      if (MEM_miss !== 0 || mem_req !== 0) begin
        mismatches++;
        $display("FAIL alu_nostall %0d: got miss=%b req=%b required 0 0", i, MEM_miss, mem_req);
      end
      @(negedge CLK);
      wq = exp_q.pop_front();
      compared++;
      if ({RegWrite1_OUT, WriteRegister1_OUT, WriteData1_OUT, Instr1_OUT} !== wq) begin
        mismatches++;
        $display("FAIL alu_wb %0d: got rw=%b reg=%0d data=%h required rw=%b reg=%0d data=%h",
                 i, RegWrite1_OUT, WriteRegister1_OUT, WriteData1_OUT, wq[69], wq[68:64], wq[63:32]);
      end
    end
  endtask

  task automatic test_loads();
    run_mem("lb",    1, 0, 1, LB,  5'd7,  32'h1001, 0, 32'h11AA3344, 1, 32'h1000, 4'b0100, 0, 32'hFFFFFFAA);
    run_mem("lbu",   1, 0, 1, LBU, 5'd7,  32'h1001, 0, 32'h11AA3344, 1, 32'h1000, 4'b0100, 0, 32'h000000AA);
    run_mem("lb3",   1, 0, 1, LB,  5'd8,  32'h1003, 0, 32'h11AA3344, 1, 32'h1000, 4'b0001, 0, 32'h00000044);
    run_mem("lh",    1, 0, 1, LH,  5'd9,  32'h4002, 0, 32'h12348001, 2, 32'h4000, 4'b0011, 0, 32'hFFFF8001);
    run_mem("lhu",   1, 0, 1, LHU, 5'd10, 32'h4001, 0, 32'h80017FFF, 1, 32'h4000, 4'b1100, 0, 32'h00008001);
    run_mem("unk",   1, 0, 1, 6'h3F, 5'd11, 32'h9002, 0, 32'h0BADF00D, 1, 32'h9000, 4'b1111, 0, 32'h0BADF00D);
    run_mem("lw_slow", 1, 0, 1, LW, 5'd12, 32'h3000, 0, 32'hCAFEF00D, 4, 32'h3000, 4'b1111, 0, 32'hCAFEF00D);
  endtask

  task automatic test_stores();
    run_mem("sh", 0, 1, 1, SH, 5'd3, 32'h2002, 32'h0000BEEF, 32'hFFFFFFFF, 1, 32'h2000, 4'b0011, 32'hBEEFBEEF, 32'h2002);
    run_mem("sb", 0, 1, 1, SB, 5'd4, 32'h5001, 32'h123456A5, 32'h0, 2, 32'h5000, 4'b0100, 32'hA5A5A5A5, 32'h5001);
    run_mem("sw", 0, 1, 0, SW, 5'd6, 32'h6003, 32'hDEADBEEF, 32'h0, 1, 32'h6000, 4'b1111, 32'hDEADBEEF, 32'h6003);
  endtask

  task automatic test_back_to_back();
    int acks0, done1;
    acks0 = ack_cnt;
    run_mem("b2b_lw", 1, 0, 1, LW, 5'd9, 32'h7000, 0, 32'h01020304, 1, 32'h7000, 4'b1111, 0, 32'h01020304);
    done1 = done_cyc;
    run_mem("b2b_sw", 0, 1, 0, SW, 5'd0, 32'h7004, 32'h55667788, 32'h0, 2, 32'h7004, 4'b1111, 32'h55667788, 32'h7004);
    compared++;
    if (start_cyc != done1 + 1) begin
      mismatches++;
      $display("FAIL b2b_start: got cycle %0d required %0d", start_cyc, done1 + 1);
    end
    drive_idle();
    @(negedge CLK);
    compared++;
    if (ack_cnt != acks0 + 2 || req_q.size() != 0) begin
      mismatches++;
      $display("FAIL b2b_count: got acks=%0d pending=%0d required acks=%0d pending=0",
               ack_cnt - acks0, req_q.size(), 2);
    end
  endtask

  task automatic test_reset_mid_access();
    int acks0;
    acks0 = ack_cnt;
    Instr1_IN = 32'h8C000000; Instr1_PC_IN = 32'h40; ALU_result1_IN = 32'h8000;
    WriteRegister1_IN = 5'd2; RegWrite1_IN = 1; MemRead1_IN = 1; MemWrite1_IN = 0;
    ALU_Control1_IN = LW; MemWriteData1_IN = '0;
    @(negedge CLK);
    #1;
    compared++;
    if (state_dbg !== ACCESS || mem_req !== 1'b1) begin
      mismatches++;
      $display("FAIL rst_pre: got state=%0d req=%b required ACCESS 1", state_dbg, mem_req);
    end
    RESET = 0;
    #1;
    compared++;
    if (mem_req !== 0 || MEM_miss !== 0 || state_dbg !== IDLE) begin
      mismatches++;
      $display("FAIL rst_abandon: got req=%b miss=%b state=%0d required 0 0 IDLE",
               mem_req, MEM_miss, state_dbg);
    end
    compared++;
    if ({RegWrite1_OUT, WriteRegister1_OUT, WriteData1_OUT, Instr1_OUT, Instr1_PC_OUT} !== '0) begin
      mismatches++;
      $display("FAIL rst_outputs: got data=%h required 0", WriteData1_OUT);
    end
    mem_ack = 1; mem_rdata = 32'hFEEDFACE;
    @(negedge CLK);
    mem_ack = 0;
    drive_idle();
    @(negedge CLK);
    RESET = 1;
    mem_ack = 1;
    #1;
    compared++;
    if (state_dbg !== IDLE || mem_req !== 0) begin
      mismatches++;
      $display("FAIL rst_late_ack: got state=%0d req=%b required IDLE 0", state_dbg, mem_req);
    end
    @(negedge CLK);
    mem_ack = 0;
    #1;
    compared++;
    if (state_dbg !== IDLE || ack_cnt != acks0 || WriteData1_OUT !== 0 || RegWrite1_OUT !== 0) begin
      mismatches++;
      $display("FAIL rst_after: got state=%0d acks=%0d data=%h rw=%b required IDLE 0 0 0",
               state_dbg, ack_cnt - acks0, WriteData1_OUT, RegWrite1_OUT);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_loads();
    test_stores();
    test_back_to_back();
    test_reset_mid_access();
    compared++;
    if (exp_q.size() != 0) begin
      mismatches++;
      $display("FAIL leftover_wb: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatches);
    $finish;
  end

endmodule
